// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART transmitter
// among NREQ byte-stream requesters, with an optional source-tag header byte.
module uart_tx_arbiter #(
    parameter int NREQ      = 2,
    parameter int IDX_W     = 1,
    parameter int HEADER_EN = 1,
    parameter int MAX_LEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   src_ready,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  grant,
    output logic              busy,
    output logic              trunc
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, sel;
    logic [7:0]       cnt;
    logic             found, xfer, last_hit, max_hit, trunc_nxt;

    function automatic int wrap(input int k);
        return (k >= NREQ) ? k - NREQ : k;
    endfunction

    // first valid requester at or after the rr pointer, wrapping around
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && src_valid[wrap(int'(rr_ptr) + i)]) begin
                sel   = IDX_W'(wrap(int'(rr_ptr) + i));
                found = 1'b1;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (state == DATA) src_ready[grant] = tx_ready;
        busy      = state != IDLE;
        tx_req    = (state == HDR) || (state == DATA && src_valid[grant]);
        tx_data   = (state == HDR)  ? {4'hA, 4'(grant)} :
                    (state == DATA) ? src_data[8*grant +: 8] : 8'h00;
        xfer      = tx_req && tx_ready;
        last_hit  = src_last[grant];
        max_hit   = (cnt + 8'd1) == 8'(MAX_LEN);
        trunc_nxt = (state == DATA) && xfer && !last_hit && max_hit;
        state_nxt = (state == IDLE) ? (found ? ((HEADER_EN != 0) ? HDR : DATA) : IDLE) :
                    (state == HDR)  ? (xfer ? DATA : HDR) :
                    ((xfer && (last_hit || max_hit)) ? IDLE : DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
            trunc  <= 1'b0;
        end else begin
            state <= state_nxt;
            trunc <= trunc_nxt;
            if (state == IDLE && found) begin
                grant  <= sel;
                rr_ptr <= IDX_W'(wrap(int'(sel) + 1));
                cnt    <= '0;
            end
            if (state == DATA && xfer) cnt <= cnt + 8'd1;
        end
    end
endmodule
